issue_stage: RTL and testbench
==============================

ISSUE_STAGE -- requirements
Module: issue_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath and register width.
REQ-002 SHALL have parameter PCLEN, default 10, program-counter width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports rs1, rs2, rd  input  5 each  decoded register indices from the fetch/decode stage.
REQ-006 SHALL have ports imm  input  XLEN, code  input  12, isLoad  input  1, isBranch  input  1, pcIn  input  PCLEN  decoded instruction fields.
REQ-007 SHALL have ports inValid  input  1 (decoded instruction present) and inReady  output  1 (stage accepts it this cycle).
REQ-008 SHALL have ports wbEn  input  1, wbRd  input  5, wbData  input  XLEN  register-file writeback from the execute/load path.
REQ-009 SHALL have port flush  input  1  taken-branch kill of the held instruction.
REQ-010 SHALL have ports outValid  output  1 and outReady  input  1  handshake toward execute.
REQ-011 SHALL have ports rs1_v, rs2_v, immOut  output  XLEN; codeOut  output  12; rdOut  output  5; isLoadOut, isBranchOut  output  1; pcOut  output  PCLEN  registered issued instruction.
REQ-012 SHALL have port stallCount  output  16  count of hazard-stall cycles.

Function
REQ-013 SHALL contain a 32 x XLEN register file; x0 reads 0 always, writes to x0 ignored.
REQ-014 SHALL write wbData to wbRd on the rising edge when wbEn=1.
REQ-015 SHALL bypass: a read of register r in the same cycle as wbEn=1, wbRd=r (r!=0) returns wbData.
REQ-016 SHALL keep a 32-bit pending scoreboard; bit r set when an instruction with rd=r (r!=0) is accepted, cleared on wbEn=1 with wbRd=r.
REQ-017 SHALL give set priority over clear when acceptance and writeback target the same register in one cycle.
REQ-018 SHALL assert hazard when inValid=1 and (pending[rs1] or pending[rs2]) is true for a nonzero index, excluding a register being written back this cycle.
REQ-019 SHALL drive inReady = !hazard and (!outValid or outReady) and !flush.
REQ-020 SHALL accept when inValid and inReady; on acceptance, capture all fields plus rs1_v/rs2_v into the output register and set outValid=1 next cycle (latency 1).
REQ-021 SHALL clear outValid on outReady=1 with no new acceptance; hold all outputs stable while outValid=1 and outReady=0.
REQ-022 SHALL on flush=1 clear outValid next cycle, accept nothing, and leave the register file and scoreboard bits of already-issued instructions untouched, except the bit set by the killed held instruction, which SHALL be cleared.
REQ-023 SHALL increment stallCount by 1 each cycle hazard=1, saturating at 16'hFFFF.
REQ-024 SHALL treat flush and wbEn in the same cycle independently; writeback always completes.

Reset
REQ-025 SHALL on reset=1 at a rising edge clear outValid, all output data registers, scoreboard, stallCount, and all 32 registers to 0.
REQ-026 SHALL during reset hold inReady=0; reset overrides flush, wbEn and acceptance in the same cycle.
REQ-027 SHALL resume acceptance the first cycle after reset deasserts.

Verification
REQ-028 Reset, then inValid=1 rs1=0 rs2=0 rd=5, outReady=1 -> outValid=1 next cycle, rs1_v=rs2_v=0, rdOut=5, pending[5]=1.
REQ-029 wbEn=1 wbRd=3 wbData=32'h1234 same cycle as accept with rs1=3 -> rs1_v=32'h1234.
REQ-030 Issue rd=7, then instr with rs2=7 -> inReady=0, stallCount increments each cycle until wbEn wbRd=7, then accepted same cycle.
REQ-031 outValid=1 with outReady=0 for 3 cycles -> outputs unchanged, inReady=0; outReady=1 -> next instr issued.
REQ-032 flush=1 while outValid=1 holding rd=9 -> outValid=0 next cycle, pending[9]=0.
REQ-033 Write x0 with 32'hFFFF_FFFF, read rs1=0 -> rs1_v=0; hazard held 70000 cycles -> stallCount=16'hFFFF.

Source files
------------

// File: rtl/issue_stage_if.sv
// Decode-to-issue and issue-to-execute handshake bundle for issue_stage.
// The slave modport is the issue stage; the master modport is its environment.
interface issue_stage_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned PCLEN = 10
);
  logic [4:0]       rs1;
  logic [4:0]       rs2;
  logic [4:0]       rd;
  logic [XLEN-1:0]  imm;
  logic [11:0]      code;
  logic             isLoad;
  logic             isBranch;
  logic [PCLEN-1:0] pcIn;
  logic             inValid;
  logic             inReady;

  logic             outValid;
  logic             outReady;
  logic [XLEN-1:0]  rs1_v;
  logic [XLEN-1:0]  rs2_v;
  logic [XLEN-1:0]  immOut;
  logic [11:0]      codeOut;
  logic [4:0]       rdOut;
  logic             isLoadOut;
  logic             isBranchOut;
  logic [PCLEN-1:0] pcOut;

  modport slave (
    input  rs1, rs2, rd, imm, code, isLoad, isBranch, pcIn, inValid, outReady,
    output inReady, outValid, rs1_v, rs2_v, immOut, codeOut, rdOut, isLoadOut, isBranchOut,
           pcOut
  );

  modport master (
    output rs1, rs2, rd, imm, code, isLoad, isBranch, pcIn, inValid, outReady,
    input  inReady, outValid, rs1_v, rs2_v, immOut, codeOut, rdOut, isLoadOut, isBranchOut,
           pcOut
  );
endinterface

// File: rtl/issue_stage.sv
// In-order issue stage: register file with writeback bypass, pending-write scoreboard,
// single output register toward execute, flush of the held instruction, stall counter.
module issue_stage #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned PCLEN = 10
) (
  input  logic             clk,
  input  logic             reset,
  issue_stage_if.slave     bus,
  input  logic             wbEn,
  input  logic [4:0]       wbRd,
  input  logic [XLEN-1:0]  wbData,
  input  logic             flush,
  output logic [15:0]      stallCount
);

  logic [XLEN-1:0]  rf_q [32];
  logic [31:0]      pending_q, pending_d;
  logic             out_valid_q;
  logic [XLEN-1:0]  rs1_v_q, rs2_v_q, imm_q;
  logic [11:0]      code_q;
  logic [4:0]       rd_q;
  logic             is_load_q, is_branch_q;
  logic [PCLEN-1:0] pc_q;
  logic [15:0]      stall_q;

  logic            wb_hit;
  logic            wb_rs1, wb_rs2;
  logic            haz_rs1, haz_rs2, hazard;
  logic            in_ready, accept;
  logic [XLEN-1:0] rs1_val, rs2_val;

  assign wb_hit = wbEn && (wbRd != 5'd0);
  assign wb_rs1 = wb_hit && (wbRd == bus.rs1);
  assign wb_rs2 = wb_hit && (wbRd == bus.rs2);

  // A register being written back this cycle is no longer a hazard.
  assign haz_rs1 = (bus.rs1 != 5'd0) && pending_q[bus.rs1] && !wb_rs1;
  assign haz_rs2 = (bus.rs2 != 5'd0) && pending_q[bus.rs2] && !wb_rs2;
  assign hazard  = bus.inValid && (haz_rs1 || haz_rs2);

  assign in_ready = !reset && !hazard && (!out_valid_q || bus.outReady) && !flush;
  assign accept   = bus.inValid && in_ready;

  always_comb begin
    rs1_val = '0;
    rs2_val = '0;
    if (bus.rs1 != 5'd0) rs1_val = wb_rs1 ? wbData : rf_q[bus.rs1];
    if (bus.rs2 != 5'd0) rs2_val = wb_rs2 ? wbData : rf_q[bus.rs2];
  end

  // Clears first, then the acceptance set so it wins on a same-register collision.
  always_comb begin
    pending_d = pending_q;
    if (wb_hit) pending_d[wbRd] = 1'b0;
    if (flush && out_valid_q && (rd_q != 5'd0)) pending_d[rd_q] = 1'b0;
    if (accept && (bus.rd != 5'd0)) pending_d[bus.rd] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
      pending_q   <= '0;
      out_valid_q <= 1'b0;
      rs1_v_q     <= '0;
      rs2_v_q     <= '0;
      imm_q       <= '0;
      code_q      <= '0;
      rd_q        <= '0;
      is_load_q   <= 1'b0;
      is_branch_q <= 1'b0;
      pc_q        <= '0;
      stall_q     <= '0;
    end else begin
      pending_q <= pending_d;
      if (wb_hit) rf_q[wbRd] <= wbData;
      if (hazard && (stall_q != 16'hFFFF)) stall_q <= stall_q + 16'd1;
      if (accept) begin
        out_valid_q <= 1'b1;
        rs1_v_q     <= rs1_val;
        rs2_v_q     <= rs2_val;
        imm_q       <= bus.imm;
        code_q      <= bus.code;
        rd_q        <= bus.rd;
        is_load_q   <= bus.isLoad;
        is_branch_q <= bus.isBranch;
        pc_q        <= bus.pcIn;
      end else if (flush || bus.outReady) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.inReady     = in_ready;
  assign bus.outValid    = out_valid_q;
  assign bus.rs1_v       = rs1_v_q;
  assign bus.rs2_v       = rs2_v_q;
  assign bus.immOut      = imm_q;
  assign bus.codeOut     = code_q;
  assign bus.rdOut       = rd_q;
  assign bus.isLoadOut   = is_load_q;
  assign bus.isBranchOut = is_branch_q;
  assign bus.pcOut       = pc_q;
  assign stallCount      = stall_q;

endmodule

// File: tb/tb_issue_stage.sv
// Directed bench for issue_stage: hand-computed expectations checked with immediate asserts.
module tb_issue_stage;
  localparam int unsigned XLEN  = 32;
  localparam int unsigned PCLEN = 10;

  logic            clk = 1'b0;
  logic            reset;
  logic            wbEn;
  logic [4:0]      wbRd;
  logic [XLEN-1:0] wbData;
  logic            flush;
  logic [15:0]     stallCount;

  int tests = 0;
  int fails = 0;

  issue_stage_if #(.XLEN(XLEN), .PCLEN(PCLEN)) bus ();

  issue_stage #(.XLEN(XLEN), .PCLEN(PCLEN)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .wbEn       (wbEn),
    .wbRd       (wbRd),
    .wbData     (wbData),
    .flush      (flush),
    .stallCount (stallCount)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic instr(input logic v, input logic [4:0] s1, input logic [4:0] s2,
                       input logic [4:0] d);
    bus.inValid = v;
    bus.rs1     = s1;
    bus.rs2     = s2;
    bus.rd      = d;
  endtask

  task automatic wb(input logic en, input logic [4:0] r, input logic [XLEN-1:0] dat);
    wbEn   = en;
    wbRd   = r;
    wbData = dat;
  endtask

  initial begin
    reset        = 1'b1;
    flush        = 1'b1;
    wb(1'b1, 5'd4, 32'hDEAD_BEEF);
    instr(1'b1, 5'd0, 5'd0, 5'd4);
    bus.imm      = '0;
    bus.code     = '0;
    bus.isLoad   = 1'b0;
    bus.isBranch = 1'b0;
    bus.pcIn     = '0;
    bus.outReady = 1'b1;

    // Reset overrides flush, writeback and acceptance.
    #1 chk("rst_inready", 64'(bus.inReady), 64'd0);
    cyc();
    cyc();
    reset = 1'b0;
    flush = 1'b0;
    wb(1'b0, 5'd0, '0);
    instr(1'b0, 5'd0, 5'd0, 5'd0);
    chk("rst_outvalid", 64'(bus.outValid), 64'd0);
    chk("rst_stall", 64'(stallCount), 64'd0);
    chk("rst_pending", 64'(dut.pending_q), 64'd0);
    chk("rst_rdout", 64'(bus.rdOut), 64'd0);

    // First issue right after reset: rd=5 with fields captured.
    instr(1'b1, 5'd0, 5'd0, 5'd5);
    bus.imm    = 32'hCAFE_0005;
    bus.code   = 12'hABC;
    bus.isLoad = 1'b1;
    bus.pcIn   = 10'h3FF;
    #1 chk("iss5_inready", 64'(bus.inReady), 64'd1);
    cyc();
    chk("iss5_valid", 64'(bus.outValid), 64'd1);
    chk("iss5_rs1v", 64'(bus.rs1_v), 64'd0);
    chk("iss5_rs2v", 64'(bus.rs2_v), 64'd0);
    chk("iss5_rdout", 64'(bus.rdOut), 64'd5);
    chk("iss5_pend", 64'(dut.pending_q[5]), 64'd1);
    chk("iss5_code", 64'(bus.codeOut), 64'hABC);
    chk("iss5_pc", 64'(bus.pcOut), 64'h3FF);
    chk("iss5_imm", 64'(bus.immOut), 64'hCAFE_0005);
    chk("iss5_load", 64'(bus.isLoadOut), 64'd1);

    // Bypass: writeback to x3 in the same cycle as reading it; x4 stayed 0 through reset.
    bus.isLoad = 1'b0;
    instr(1'b1, 5'd3, 5'd4, 5'd6);
    wb(1'b1, 5'd3, 32'h1234);
    cyc();
    chk("byp_rs1v", 64'(bus.rs1_v), 64'h1234);
    chk("byp_rs2v", 64'(bus.rs2_v), 64'd0);
    chk("byp_rdout", 64'(bus.rdOut), 64'd6);
    instr(1'b0, 5'd0, 5'd0, 5'd0);
    wb(1'b1, 5'd5, 32'h55);
    cyc();
    chk("drain_valid", 64'(bus.outValid), 64'd0);
    wb(1'b1, 5'd6, 32'h66);
    cyc();
    wb(1'b0, 5'd0, '0);
    chk("wb_pend_clr", 64'(dut.pending_q), 64'd0);

    // RAW hazard on x7 stalls until its writeback, then issues that same cycle.
    instr(1'b1, 5'd0, 5'd0, 5'd7);
    cyc();
    chk("iss7_pend", 64'(dut.pending_q[7]), 64'd1);
    instr(1'b1, 5'd5, 5'd7, 5'd8);
    for (int i = 1; i <= 3; i++) begin
      #1 chk("haz_inready", 64'(bus.inReady), 64'd0);
      cyc();
      chk("haz_stall", 64'(stallCount), 64'(i));
    end
    wb(1'b1, 5'd7, 32'h77);
    #1 chk("haz_release", 64'(bus.inReady), 64'd1);
    cyc();
    wb(1'b0, 5'd0, '0);
    chk("haz_rs1v", 64'(bus.rs1_v), 64'h55);
    chk("haz_rs2v", 64'(bus.rs2_v), 64'h77);
    chk("haz_rdout", 64'(bus.rdOut), 64'd8);
    chk("haz_stall_hold", 64'(stallCount), 64'd3);
    chk("haz_pend", 64'(dut.pending_q), 64'h100);

    // Backpressure: outputs hold for 3 cycles, then the waiting instruction issues.
    bus.outReady = 1'b0;
    instr(1'b1, 5'd6, 5'd0, 5'd10);
    for (int i = 0; i < 3; i++) begin
      #1 chk("bp_inready", 64'(bus.inReady), 64'd0);
      cyc();
      chk("bp_valid", 64'(bus.outValid), 64'd1);
      chk("bp_rdout", 64'(bus.rdOut), 64'd8);
      chk("bp_rs2v", 64'(bus.rs2_v), 64'h77);
    end
    chk("bp_stall", 64'(stallCount), 64'd3);
    bus.outReady = 1'b1;
    #1 chk("bp_release", 64'(bus.inReady), 64'd1);
    cyc();
    chk("bp_rdout10", 64'(bus.rdOut), 64'd10);
    chk("bp_rs1v", 64'(bus.rs1_v), 64'h66);
    instr(1'b0, 5'd0, 5'd0, 5'd0);
    wb(1'b1, 5'd8, 32'h88);
    cyc();
    wb(1'b1, 5'd10, 32'hAA);
    cyc();
    wb(1'b0, 5'd0, '0);
    chk("bp_pend_clr", 64'(dut.pending_q), 64'd0);

    // Flush kills held rd=9, blocks the new instruction, and writeback still lands.
    bus.outReady = 1'b0;
    instr(1'b1, 5'd0, 5'd0, 5'd9);
    cyc();
    chk("fl_pend9", 64'(dut.pending_q[9]), 64'd1);
    flush = 1'b1;
    instr(1'b1, 5'd0, 5'd0, 5'd11);
    wb(1'b1, 5'd12, 32'hCC);
    #1 chk("fl_inready", 64'(bus.inReady), 64'd0);
    cyc();
    flush = 1'b0;
    wb(1'b0, 5'd0, '0);
    chk("fl_valid", 64'(bus.outValid), 64'd0);
    chk("fl_pend", 64'(dut.pending_q), 64'd0);

    // x0 write ignored, also not bypassed; x12 written during flush.
    bus.outReady = 1'b1;
    instr(1'b1, 5'd0, 5'd12, 5'd13);
    wb(1'b1, 5'd0, 32'hFFFF_FFFF);
    cyc();
    wb(1'b0, 5'd0, '0);
    chk("x0_byp", 64'(bus.rs1_v), 64'd0);
    chk("x12_rs2v", 64'(bus.rs2_v), 64'hCC);
    instr(1'b1, 5'd0, 5'd0, 5'd0);
    cyc();
    chk("x0_read", 64'(bus.rs1_v), 64'd0);
    chk("x0_nopend", 64'(dut.pending_q), 64'h2000);

    // Long hazard on x13: counter reaches FFFF and saturates.
    instr(1'b1, 5'd13, 5'd0, 5'd15);
    repeat (65531) cyc();
    chk("sat_fffe", 64'(stallCount), 64'hFFFE);
    cyc();
    chk("sat_ffff", 64'(stallCount), 64'hFFFF);
    repeat (4467) cyc();
    chk("sat_hold", 64'(stallCount), 64'hFFFF);

    // Reset mid-run, then acceptance resumes on the first cycle after.
    reset = 1'b1;
    instr(1'b1, 5'd0, 5'd0, 5'd14);
    wb(1'b1, 5'd2, 32'h22);
    #1 chk("rst2_inready", 64'(bus.inReady), 64'd0);
    cyc();
    reset = 1'b0;
    wb(1'b0, 5'd0, '0);
    chk("rst2_stall", 64'(stallCount), 64'd0);
    chk("rst2_pend", 64'(dut.pending_q), 64'd0);
    chk("rst2_valid", 64'(bus.outValid), 64'd0);
    instr(1'b1, 5'd2, 5'd0, 5'd14);
    #1 chk("rst2_resume", 64'(bus.inReady), 64'd1);
    cyc();
    chk("rst2_rdout", 64'(bus.rdOut), 64'd14);
    chk("rst2_rs1v", 64'(bus.rs1_v), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
